// File: rtl/uart_receiver.sv
// Purpose : serial-to-parallel UART receiver for 8-E-1 frames on an oversampled bit clock.
// Latency : rx_done pulses 1 clk after the oversample tick that samples the stop bit.
// Backpress: none; the consumer must capture data_out and flags on the rx_done strobe.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   inrx       - one-clk oversample enable at OVERSAMPLE x baud
//   rx         - serial line, idles high, asynchronous to clk
//   data_out   - last received byte
//   rx_done    - one-clk strobe when a frame completes
//   parity_err - even-parity mismatch on the last frame
//   frame_err  - stop bit of the last frame read as 0
//   busy       - receiver is anywhere other than idle
module uart_receiver #(
    // Ticks per bit; must be a power of two and at least 8.
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inrx,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       rx_done,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(OVERSAMPLE);

    // Mid-bit point of the start bit, and the full-bit point for every later bit.
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      idx;
    logic [7:0]      sh;
    logic            par_bad;

    // Two-flop synchronizer. Both flops reset to the idle level so that
    // reset release never looks like a start bit.
    logic            rx_meta;
    logic            rxs;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Receive FSM. Every state transition happens only on an oversample tick,
    // so holding inrx low freezes the receiver wherever it is.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= 3'd0;
            sh         <= 8'h00;
            par_bad    <= 1'b0;
            data_out   <= 8'h00;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // rx_done is only ever set for the single cycle after the stop sample.
            rx_done <= 1'b0;

            if (inrx) begin
                case (state)
                    S_IDLE: begin
                        if (!rxs) begin
                            state <= S_START;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end

                    S_START: begin
                        if (cnt == CNT_MID) begin
                            if (!rxs) begin
                                // Start bit still low at mid-bit: genuine frame.
                                // cnt restarts so the next sample lands mid-D0.
                                state <= S_DATA;
                                cnt   <= '0;
                                idx   <= 3'd0;
                            end else begin
                                // Line went back high: a glitch, drop it silently.
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    S_DATA: begin
                        // cnt wraps naturally from CNT_LAST back to 0.
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            // Shift in at the top so D0 ends up in sh[0].
                            sh  <= {rxs, sh[7:1]};
                            idx <= idx + 3'd1;
                            if (idx == 3'd7) begin
                                state <= S_PARITY;
                            end
                        end
                    end

                    S_PARITY: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            // Even parity: data plus parity bit must have an even
                            // number of ones, so any odd total is an error.
                            par_bad <= rxs ^ (^sh);
                            state   <= S_STOP;
                        end
                    end

                    S_STOP: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            data_out   <= sh;
                            parity_err <= par_bad;
                            frame_err  <= ~rxs;
                            rx_done    <= 1'b1;
                            if (rxs) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                // Stop bit low: the line may be held in break.
                                // Wait for it to recover before hunting for a
                                // new start bit.
                                state <= S_BREAK;
                            end
                        end
                    end

                    S_BREAK: begin
                        if (rxs) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Purpose : self-checking bench for uart_receiver using directed frame vectors.
// Latency : frames are driven at 16 ticks per bit with a tick every DIV clocks.
// Backpress: none; a monitor records every rx_done strobe as it happens.
module tb_uart_receiver;

    localparam int DIV = 4;
    localparam int OS  = 16;

    logic       clk;
    logic       reset;
    logic       inrx;
    logic       rx;
    logic [7:0] data_out;
    logic       rx_done;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    uart_receiver #(.OVERSAMPLE(OS)) dut (
        .clk        (clk),
        .reset      (reset),
        .inrx       (inrx),
        .rx         (rx),
        .data_out   (data_out),
        .rx_done    (rx_done),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oversample enable: one clk high out of every DIV.
    initial begin
        inrx = 1'b0;
        forever begin
            repeat (DIV - 1) begin
                @(posedge clk);
                #1 inrx = 1'b0;
            end
            @(posedge clk);
            #1 inrx = 1'b1;
        end
    end

    int pass_cnt = 0;
    int total    = 0;

    // rx_done monitor: records the outputs seen with every strobe.
    int         done_cnt  = 0;
    int         wide_strb = 0;
    logic       prev_done = 1'b0;
    logic [7:0] rec_data [64];
    logic       rec_pe   [64];
    logic       rec_fe   [64];
    logic       rec_busy [64];

    always @(negedge clk) begin
        if (rx_done) begin
            rec_data[done_cnt % 64] = data_out;
            rec_pe[done_cnt % 64]   = parity_err;
            rec_fe[done_cnt % 64]   = frame_err;
            rec_busy[done_cnt % 64] = busy;
            done_cnt = done_cnt + 1;
            if (prev_done) wide_strb = wide_strb + 1;
        end
        prev_done = rx_done;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Wait for n oversample ticks as seen by the DUT at the rising edge.
    task automatic wait_ticks(input int n);
        int seen;
        seen = 0;
        while (seen < n) begin
            @(posedge clk);
            if (inrx) seen = seen + 1;
        end
    endtask

    task automatic send_bit(input logic b);
        #1 rx = b;
        wait_ticks(OS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       s;
        logic [7:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
        logic       exp_busy;
    } vec_t;

    vec_t vecs [9];
    int   snap;

    initial begin
        //              data   par   stop  exp_d  pe    fe    busy@done
        vecs[0] = '{8'hAA, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'hAA, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{8'hF0, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b1, 1'b1};

        reset = 1'b0;
        rx    = 1'b1;
        #15;
        check("reset data_out",   {24'h0, data_out}, 32'h00);
        check("reset rx_done",    {31'h0, rx_done}, 32'h0);
        check("reset parity_err", {31'h0, parity_err}, 32'h0);
        check("reset frame_err",  {31'h0, frame_err}, 32'h0);
        check("reset busy",       {31'h0, busy}, 32'h0);
        #5 reset = 1'b1;
        wait_ticks(20);
        check("idle busy", {31'h0, busy}, 32'h0);

        // Single frames with idle gaps between them.
        for (int v = 0; v < 9; v++) begin
            snap = done_cnt;
            send_frame(vecs[v].d, vecs[v].p, vecs[v].s);
            wait_ticks(2);
            check($sformatf("vec%0d strobes", v), done_cnt - snap, 1);
            check($sformatf("vec%0d data", v), {24'h0, rec_data[snap % 64]}, {24'h0, vecs[v].exp_d});
            check($sformatf("vec%0d parity_err", v), {31'h0, rec_pe[snap % 64]}, {31'h0, vecs[v].exp_pe});
            check($sformatf("vec%0d frame_err", v), {31'h0, rec_fe[snap % 64]}, {31'h0, vecs[v].exp_fe});
            check($sformatf("vec%0d busy at done", v), {31'h0, rec_busy[snap % 64]}, {31'h0, vecs[v].exp_busy});
            if (!vecs[v].s) begin
                #1 rx = 1'b1;
            end
            wait_ticks(8);
        end

        // Back-to-back frames, no idle time between stop and next start.
        snap = done_cnt;
        send_frame(8'h07, 1'b1, 1'b1);
        send_frame(8'h80, 1'b1, 1'b1);
        wait_ticks(2);
        check("b2b strobes", done_cnt - snap, 2);
        check("b2b first data", {24'h0, rec_data[snap % 64]}, 32'h07);
        check("b2b second data", {24'h0, rec_data[(snap + 1) % 64]}, 32'h80);
        check("b2b first flags", {30'h0, rec_pe[snap % 64], rec_fe[snap % 64]}, 32'h0);
        check("b2b second flags", {30'h0, rec_pe[(snap + 1) % 64], rec_fe[(snap + 1) % 64]}, 32'h0);
        wait_ticks(8);

        // Bad stop bit then a line held low: must sit in break, no re-trigger.
        snap = done_cnt;
        send_frame(8'h55, 1'b0, 1'b0);
        wait_ticks(2);
        check("brk strobes", done_cnt - snap, 1);
        check("brk data", {24'h0, rec_data[snap % 64]}, 32'h55);
        check("brk frame_err", {31'h0, rec_fe[snap % 64]}, 32'h1);
        check("brk parity_err", {31'h0, rec_pe[snap % 64]}, 32'h0);
        wait_ticks(500);
        check("brk no retrigger", done_cnt - snap, 1);
        check("brk busy held", {31'h0, busy}, 32'h1);
        #1 rx = 1'b1;
        wait_ticks(4);
        check("brk busy released", {31'h0, busy}, 32'h0);
        wait_ticks(8);

        // Glitch: 4-tick low pulse must be rejected with outputs untouched.
        snap = done_cnt;
        #1 rx = 1'b0;
        wait_ticks(4);
        #1 rx = 1'b1;
        wait_ticks(20);
        check("glitch strobes", done_cnt - snap, 0);
        check("glitch busy", {31'h0, busy}, 32'h0);
        check("glitch data held", {24'h0, data_out}, 32'h55);
        check("glitch frame_err held", {31'h0, frame_err}, 32'h1);
        send_frame(8'h5A, 1'b0, 1'b1);
        wait_ticks(2);
        check("post-glitch strobes", done_cnt - snap, 1);
        check("post-glitch data", {24'h0, rec_data[snap % 64]}, 32'h5A);
        check("post-glitch flags", {30'h0, rec_pe[snap % 64], rec_fe[snap % 64]}, 32'h0);
        wait_ticks(8);

        // Leave both flags set so the reset test below has something to clear.
        snap = done_cnt;
        send_frame(8'h81, 1'b1, 1'b0);
        wait_ticks(2);
        check("pre-reset flags", {30'h0, parity_err, frame_err}, 32'h3);
        #1 rx = 1'b1;
        wait_ticks(8);

        // Reset asserted in the middle of data bit 3.
        snap = done_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        #1 rx = 1'b0;
        wait_ticks(8);
        check("mid-frame busy", {31'h0, busy}, 32'h1);
        #1 reset = 1'b0;
        #1;
        check("mid-reset data_out", {24'h0, data_out}, 32'h00);
        check("mid-reset flags", {30'h0, parity_err, frame_err}, 32'h0);
        check("mid-reset busy", {31'h0, busy}, 32'h0);
        check("mid-reset rx_done", {31'h0, rx_done}, 32'h0);
        repeat (5) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        wait_ticks(20);
        check("mid-reset strobes", done_cnt - snap, 0);
        send_frame(8'h3C, 1'b0, 1'b1);
        wait_ticks(2);
        check("post-reset strobes", done_cnt - snap, 1);
        check("post-reset data", {24'h0, rec_data[snap % 64]}, 32'h3C);
        check("post-reset flags", {30'h0, rec_pe[snap % 64], rec_fe[snap % 64]}, 32'h0);

        check("strobe width", wide_strb, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver, the receive end of the existing UART link. It consumes the `inrx` 16x-oversample enable from `baud_generator` and recovers 11-bit frames from the serial line. Each frame is start bit 0, D0–D7 LSB-first, even parity, stop bit 1, the same frame the UART transmitter emits. It presents each received byte with a one-cycle `rx_done` strobe plus parity and framing status.

## Interface
- `OVERSAMPLE`, default 16: `inrx` ticks per bit. Must be a power of two, at least 8. The mid-bit sample point is `OVERSAMPLE/2`.
- `clk` in 1: system clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset (0 = reset).
- `inrx` in 1: oversample enable from `baud_generator`, one `clk` wide, at `OVERSAMPLE` × baud.
- `rx` in 1: serial line. Idles high. Asynchronous to `clk`.
- `data_out` out 8: last received byte. Reset value 8'h00.
- `rx_done` out 1: one-`clk` strobe when a frame completes. Reset value 0.
- `parity_err` out 1: parity status of the last frame. Valid from `rx_done` until the next `rx_done`. Reset value 0.
- `frame_err` out 1: stop bit of the last frame read as 0. Same validity as `parity_err`. Reset value 0.
- `busy` out 1: high in any state other than IDLE. Reset value 0.

## Operation
- `rx` passes through a 2-flop synchronizer whose flops reset to 1. All decisions below use the synchronized value `rxs`.
- Tick counter `cnt` is log2(OVERSAMPLE) bits and advances only on `inrx`. Bit index `idx` is 3 bits. Shift register `sh` is 8 bits.
- **IDLE:** on an `inrx` tick with `rxs`=0, go to START with `cnt`=0.
- **START:** count ticks. On the tick where `cnt` reaches `OVERSAMPLE/2-1`:
  - `rxs`=0: go to DATA with `cnt`=0 and `idx`=0.
  - `rxs`=1: treat it as a glitch and return to IDLE. No strobe, no flag change.
- **DATA:** on each tick where `cnt`=`OVERSAMPLE-1`, sample `rxs` into `sh[7]` and shift right, which gives LSB-first order. After `idx`=7 is sampled, go to PARITY.
- **PARITY:** sample on `cnt`=`OVERSAMPLE-1`. The parity error term is `rxs` XOR (^`sh`). Go to STOP.
- **STOP:** sample on `cnt`=`OVERSAMPLE-1`. On the next `clk`:
  - Load `data_out` from `sh`.
  - Load `parity_err` and `frame_err` (= ~`rxs`).
  - Pulse `rx_done`.
  - If the stop bit was 1, go to IDLE. If it was 0, go to BREAK.
- **BREAK:** wait for `rxs`=1, then go to IDLE. A line held low must not re-trigger a frame.
- `data_out` and both flags are written only when `rx_done` pulses. They hold otherwise.
- Reset asserted at any time, including mid-frame, immediately forces all outputs and state to their reset values. The partial frame is discarded.

## Timing
- Synchronizer latency is 2 `clk` from an `rx` edge to `rxs`.
- From the first tick that sees `rxs`=0, the mid-start sample falls `OVERSAMPLE/2` ticks later. Each following sample (8 data, parity, stop) is `OVERSAMPLE` ticks after the previous one. With the defaults that is 8 + 10×16 = 168 ticks to the stop sample.
- `rx_done` rises exactly 1 `clk` after the `inrx` tick that samples the stop bit and stays high for 1 `clk`.
- `busy` rises 1 `clk` after the IDLE→START tick. It falls in the same cycle `rx_done` is high when the next state is IDLE.
- A new start bit is accepted on the first `inrx` tick after returning to IDLE, so back-to-back frames need no extra idle time.
- If `inrx` is tied low, the FSM holds its current state indefinitely.

## Test plan
- **Good frame:** `baud_generator` with `baud_sel`=2'b10, reset low 20 ns then high. Drive the frame for 8'hAA with parity 0 and stop 1 → `rx_done` pulses once, `data_out`=8'hAA, `parity_err`=0, `frame_err`=0.
- **Back-to-back frames:** send 8'h07 (parity 1) immediately followed by 8'h80 (parity 1) with no idle gap → two `rx_done` pulses, `data_out`=8'h07 then 8'h80, no flags set.
- **Bad parity and bad stop:**
  - 8'hAA with parity bit 1 → `data_out`=8'hAA, `parity_err`=1, `frame_err`=0.
  - 8'h55 with stop bit 0 → `frame_err`=1. `busy` stays high (BREAK) until `rx` returns to 1, and there is no second `rx_done` while `rx` is held low for 500 ticks.
- **Glitch rejection:** a low pulse on `rx` lasting 4 `inrx` ticks → no `rx_done`, `busy` returns to 0, outputs unchanged. A valid frame that follows is received correctly.
- **Reset mid-frame:** assert `reset`=0 during data bit 3 of a frame → all outputs reset to 0 immediately, with no `rx_done`. After release, a new 8'h3C frame is received with no flags set.
